// File: rtl/seq_prim_bank_if.sv
// Signal bundle for seq_prim_bank: register slice data/enable and decoder select/result.
interface seq_prim_bank_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] q_r;
  logic             en;
  logic [WIDTH-1:0] d_e;
  logic [WIDTH-1:0] q_e;
  logic [1:0]       dec_a;
  logic [3:0]       dec_y;

  modport master (
    output d_r, en, d_e, dec_a,
    input  q_r, q_e, dec_y
  );

  modport slave (
    input  d_r, en, d_e, dec_a,
    output q_r, q_e, dec_y
  );
endinterface

// File: rtl/seq_prim_bank.sv
// Bank of primitives: plain register, load-enabled register and 2-to-4 one-hot decoder.
// Both registers clear asynchronously to RST_VAL while reset is low.
module seq_prim_bank #(
  parameter int unsigned     WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             ph1,
  input  logic             reset,
  seq_prim_bank_if.slave   bus
);

  logic [WIDTH-1:0] q_r_q;
  logic [WIDTH-1:0] q_e_q;

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      q_r_q <= RST_VAL;
    end else begin
      q_r_q <= bus.d_r;
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      q_e_q <= RST_VAL;
    end else if (bus.en) begin
      q_e_q <= bus.d_e;
    end
  end

  assign bus.q_r = q_r_q;
  assign bus.q_e = q_e_q;

  // Purely combinational; independent of clock and reset.
  always_comb begin
    bus.dec_y = 4'b0001 << bus.dec_a;
  end

endmodule

// File: tb/tb_seq_prim_bank.sv
// Scoreboard bench for seq_prim_bank: a 32-bit instance under directed and random stimulus,
// plus a 2-bit instance wired as a self-incrementing pointer.
module tb_seq_prim_bank;

  logic ph1 = 1'b0;
  logic reset = 1'b1;
  logic p_en = 1'b0;

  always #5 ph1 = ~ph1;

  seq_prim_bank_if #(.WIDTH(32)) m_if ();
  seq_prim_bank_if #(.WIDTH(2))  p_if ();

  seq_prim_bank #(.WIDTH(32), .RST_VAL(32'h0)) u_main (
    .ph1   (ph1),
    .reset (reset),
    .bus   (m_if)
  );

  seq_prim_bank #(.WIDTH(2), .RST_VAL(2'd0)) u_ptr (
    .ph1   (ph1),
    .reset (reset),
    .bus   (p_if)
  );

  // Pointer usage: increment on advance, decode the current slot.
  assign p_if.d_e   = p_if.q_e + 2'd1;
  assign p_if.dec_a = p_if.q_e;
  assign p_if.d_r   = 2'd0;
  assign p_if.en    = p_en;

  typedef struct {
    logic [31:0] q_r;
    logic [31:0] q_e;
    logic [3:0]  dec;
    logic [1:0]  ptr;
    logic [3:0]  pdec;
  } exp_t;

  exp_t sb_q[$];
  event mon_ev;
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state.
  logic [31:0] m_qr = '0;
  logic [31:0] m_qe = '0;
  int          m_ptr = 0;

  function automatic logic [3:0] onehot(input int idx);
    return 4'(2 ** idx);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic push_exp();
    exp_t e;
    e.q_r  = m_qr;
    e.q_e  = m_qe;
    e.dec  = onehot(int'(m_if.dec_a));
    e.ptr  = 2'(m_ptr);
    e.pdec = onehot(m_ptr);
    sb_q.push_back(e);
  endtask

  // Called at a falling edge with inputs set: predicts the next rising edge, waits a cycle.
  task automatic step();
    if (!reset) begin
      m_qr  = '0;
      m_qe  = '0;
      m_ptr = 0;
    end else begin
      m_qr = m_if.d_r;
      if (m_if.en) m_qe = m_if.d_e;
      if (p_en) m_ptr = (m_ptr + 1) % 4;
    end
    push_exp();
    @(negedge ph1);
  endtask

  // Pull reset low between edges and expect immediate clearing; leaves reset low.
  task automatic async_reset_check();
    #2;
    reset = 1'b0;
    #1;
    m_qr  = '0;
    m_qe  = '0;
    m_ptr = 0;
    push_exp();
    ->mon_ev;
    step();
  endtask

  initial begin
    forever begin
      @(posedge ph1);
      #1;
      ->mon_ev;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("q_r", m_if.q_r, e.q_r);
        chk("q_e", m_if.q_e, e.q_e);
        chk("dec_y", 32'(m_if.dec_y), 32'(e.dec));
        chk("ptr_q_e", 32'(p_if.q_e), 32'(e.ptr));
        chk("ptr_dec_y", 32'(p_if.dec_y), 32'(e.pdec));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_if.d_r   = 32'hDDCCBBAA;
    m_if.d_e   = 32'hDDCCBBAA;
    m_if.en    = 1'b1;
    m_if.dec_a = 2'd0;
    #1;
    reset = 1'b0;
    step();
    step();
    // Reset clears, then first edge after release loads.
    async_reset_check();
    reset = 1'b1;
    step();

    // Enable hold.
    m_if.d_e = 32'h21212121;
    step();
    m_if.en  = 1'b0;
    m_if.d_e = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) step();
    m_if.en = 1'b1;
    step();

    // Plain register tracks with one-edge lag, decoder sweep alongside.
    for (int i = 0; i < 4; i++) begin
      m_if.d_r   = 32'(i);
      m_if.dec_a = 2'(i);
      step();
    end

    // Async reset mid-cycle from a loaded state.
    m_if.d_r = 32'hBEADBEEF;
    m_if.d_e = 32'hBEADBEEF;
    step();
    async_reset_check();
    reset = 1'b1;

    // Pointer wrap from reset: 1,2,3,0,1.
    p_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    p_en = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      m_if.d_r   = $urandom;
      m_if.d_e   = $urandom;
      m_if.en    = 1'($urandom_range(0, 1));
      m_if.dec_a = 2'($urandom_range(0, 3));
      p_en       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        async_reset_check();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    n_total++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
